// File: rtl/adc_scan_filter.sv
// adc_scan_filter: 3-channel ADC scan sequencer with per-channel IIR filter, Vfc difference and over-voltage trip
module adc_scan_filter #(
    parameter int          FILT_SHIFT = 2,
    parameter logic [15:0] OV_LIMIT   = 16'h7800,
    parameter int          OV_COUNT   = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] sample_i,
    input  logic        sample_valid_i,
    input  logic        fault_clr_i,
    output logic [1:0]  channel_o,
    output logic [15:0] v_out_o,
    output logic [15:0] v_fc_o,
    output logic        frame_valid_o,
    output logic        ov_fault_o
);
    localparam int         W      = 16 + FILT_SHIFT;
    localparam logic [3:0] OV_MAX = 4'(OV_COUNT);

    logic [W-1:0] acc [0:2];
    logic [2:0]   seen;
    logic         s1_v;
    logic [1:0]   s1_ch;
    logic [3:0]   ov_cnt;
    logic [15:0]  x;
    logic         strobe;
    logic         seen_sel;
    logic [W-1:0] acc_sel;
    logic [W-1:0] acc_new;
    logic [15:0]  y0;
    logic [15:0]  y1;
    logic [15:0]  y2;
    logic [15:0]  y1_new;

    // negative codes clamp to zero; first sample of a channel preloads so y = x at once
    always_comb begin
        x        = sample_i[15] ? 16'h0000 : sample_i;
        strobe   = sample_valid_i && channel_o != 2'd3;
        acc_sel  = channel_o == 2'd0 ? acc[0] : channel_o == 2'd1 ? acc[1] : acc[2];
        seen_sel = channel_o == 2'd0 ? seen[0] : channel_o == 2'd1 ? seen[1] : seen[2];
        acc_new  = seen_sel ? acc_sel - (acc_sel >> FILT_SHIFT) + W'(x) : W'(x) << FILT_SHIFT;
        y0       = 16'(acc[0] >> FILT_SHIFT);
        y1       = 16'(acc[1] >> FILT_SHIFT);
        y2       = 16'(acc[2] >> FILT_SHIFT);
        y1_new   = 16'(acc_new >> FILT_SHIFT);
    end

    // channel sequencer; an illegal channel 3 recovers to 0
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            channel_o <= 2'd0;
        else
            channel_o <= channel_o == 2'd3 ? 2'd0 :
                         sample_valid_i ? (channel_o == 2'd2 ? 2'd0 : channel_o + 2'd1) : channel_o;
    end

    // stage 1: per-channel accumulator update and stage-2 handoff
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 3; i++) acc[i] <= '0;
            seen  <= 3'b000;
            s1_v  <= 1'b0;
            s1_ch <= 2'd0;
        end else begin
            s1_v  <= strobe;
            s1_ch <= channel_o;
            if (strobe) begin
                acc[channel_o]  <= acc_new;
                seen[channel_o] <= 1'b1;
            end
        end
    end

    // stage 2: registered filtered outputs, Vfc floored at zero, frame pulse on a completed ch2
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v_out_o       <= 16'h0000;
            v_fc_o        <= 16'h0000;
            frame_valid_o <= 1'b0;
        end else begin
            frame_valid_o <= s1_v && s1_ch == 2'd2 && &seen;
            if (s1_v) begin
                v_out_o <= y1;
                v_fc_o  <= y0 >= y2 ? y0 - y2 : 16'h0000;
            end
        end
    end

    // over-voltage run counter and sticky fault; a trip outranks a clear
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ov_cnt     <= 4'd0;
            ov_fault_o <= 1'b0;
        end else begin
            if (strobe && channel_o == 2'd1)
                ov_cnt <= y1_new > OV_LIMIT ? (ov_cnt == OV_MAX ? ov_cnt : ov_cnt + 4'd1) : 4'd0;
            else if (fault_clr_i)
                ov_cnt <= 4'd0;
            ov_fault_o <= ov_cnt == OV_MAX ? 1'b1 : fault_clr_i ? 1'b0 : ov_fault_o;
        end
    end
endmodule

// File: tb/tb_adc_scan_filter.sv
// tb_adc_scan_filter: directed table-driven checks of adc_scan_filter at K=2 and K=0
module tb_adc_scan_filter;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic [15:0] sample;
    logic        sample_valid;
    logic        fault_clr;
    logic [1:0]  ch_k2, ch_k0;
    logic [15:0] vout_k2, vout_k0, vfc_k2, vfc_k0;
    logic        fv_k2, fv_k0, ov_k2, ov_k0;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        bit          rst;
        logic [15:0] c0, c1, c2, vout, vfc;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    adc_scan_filter u_k2 (
        .clk_i(clk), .rst_ni(rst_ni), .sample_i(sample), .sample_valid_i(sample_valid),
        .fault_clr_i(fault_clr), .channel_o(ch_k2), .v_out_o(vout_k2), .v_fc_o(vfc_k2),
        .frame_valid_o(fv_k2), .ov_fault_o(ov_k2)
    );

    adc_scan_filter #(.FILT_SHIFT(0)) u_k0 (
        .clk_i(clk), .rst_ni(rst_ni), .sample_i(sample), .sample_valid_i(sample_valid),
        .fault_clr_i(fault_clr), .channel_o(ch_k0), .v_out_o(vout_k0), .v_fc_o(vfc_k0),
        .frame_valid_o(fv_k0), .ov_fault_o(ov_k0)
    );

    function automatic logic [15:0] cond(input logic [15:0] v);
        return v[15] ? 16'h0000 : v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] v);
        sample       = v;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle(1);
        rst_ni = 1'b1;
    endtask

    // sends ch0, ch1, ch2 with gaps; returns at the ch2 strobe + 2 cycles
    task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        logic [15:0] s [3];
        s[0] = a;
        s[1] = b;
        s[2] = c;
        for (int i = 0; i < 3; i++) begin
            chk("channel", 16'(ch_k2), 16'(i));
            strobe(s[i]);
            chk("channel_adv", 16'(ch_k2), 16'((i + 1) % 3));
            idle(1);
            if (i < 2) begin
                chk("fv_early", 16'(fv_k2), 16'h0000);
                idle(8);
            end
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h5000, 16'h3000, 16'h1000, 16'h3000, 16'h4000};
        tbl[1] = '{1'b1, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0000};
        tbl[2] = '{1'b0, 16'h1000, 16'h2000, 16'h1000, 16'h1400, 16'h0000};
        tbl[3] = '{1'b0, 16'h1000, 16'h2000, 16'h1000, 16'h1700, 16'h0000};
        tbl[4] = '{1'b0, 16'h1000, 16'h2000, 16'h1000, 16'h1940, 16'h0000};
        tbl[5] = '{1'b1, 16'h1000, 16'h8123, 16'h2000, 16'h0000, 16'h0000};
        tbl[6] = '{1'b0, 16'h3000, 16'h8123, 16'h2000, 16'h0000, 16'h0000};
        tbl[7] = '{1'b0, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 16'h0600};
        tbl[8] = '{1'b1, 16'h2000, 16'h0100, 16'hF000, 16'h0100, 16'h2000};

        rst_ni       = 1'b0;
        sample       = 16'h0000;
        sample_valid = 1'b0;
        fault_clr    = 1'b0;
        idle(2);
        chk("rst_channel", 16'(ch_k2), 16'h0000);
        chk("rst_vout", vout_k2, 16'h0000);
        chk("rst_vfc", vfc_k2, 16'h0000);
        chk("rst_fv", 16'(fv_k2), 16'h0000);
        chk("rst_ov", 16'(ov_k2), 16'h0000);
        rst_ni = 1'b1;
        idle(2);

        for (int v = 0; v < 9; v++) begin
            logic [15:0] a0, a2;
            if (tbl[v].rst) do_reset();
            run_frame(tbl[v].c0, tbl[v].c1, tbl[v].c2);
            a0 = cond(tbl[v].c0);
            a2 = cond(tbl[v].c2);
            chk("fv_k2", 16'(fv_k2), 16'h0001);
            chk("fv_k0", 16'(fv_k0), 16'h0001);
            chk("vout_k2", vout_k2, tbl[v].vout);
            chk("vfc_k2", vfc_k2, tbl[v].vfc);
            chk("vout_k0", vout_k0, cond(tbl[v].c1));
            chk("vfc_k0", vfc_k0, a0 >= a2 ? a0 - a2 : 16'h0000);
            idle(1);
            chk("fv_single", 16'(fv_k2), 16'h0000);
            idle(3);
        end

        // over-voltage run on the K=0 instance
        do_reset();
        run_frame(16'h0000, 16'h7900, 16'h0000);
        chk("ov_1st", 16'(ov_k0), 16'h0000);
        run_frame(16'h0000, 16'h7900, 16'h0000);
        chk("ov_2nd", 16'(ov_k0), 16'h0000);
        run_frame(16'h0000, 16'h7000, 16'h0000);
        chk("ov_break", 16'(ov_k0), 16'h0000);
        run_frame(16'h0000, 16'h7900, 16'h0000);
        run_frame(16'h0000, 16'h7900, 16'h0000);
        chk("ov_run2", 16'(ov_k0), 16'h0000);
        strobe(16'h0000);
        idle(5);
        strobe(16'h7900);
        chk("ov_trip_n1", 16'(ov_k0), 16'h0000);
        idle(1);
        chk("ov_trip_n2", 16'(ov_k0), 16'h0001);
        idle(5);
        strobe(16'h0000);
        idle(5);
        run_frame(16'h0000, 16'h1000, 16'h0000);
        chk("ov_sticky", 16'(ov_k0), 16'h0001);
        chk("vout_in_fault", vout_k0, 16'h1000);
        fault_clr = 1'b1;
        idle(1);
        fault_clr = 1'b0;
        chk("ov_cleared", 16'(ov_k0), 16'h0000);
        idle(3);
        run_frame(16'h0000, 16'h7900, 16'h0000);
        run_frame(16'h0000, 16'h7900, 16'h0000);
        strobe(16'h0000);
        idle(5);
        strobe(16'h7900);
        chk("ov_pre_set", 16'(ov_k0), 16'h0000);
        fault_clr = 1'b1;
        idle(1);
        fault_clr = 1'b0;
        chk("ov_set_wins", 16'(ov_k0), 16'h0001);
        idle(2);
        chk("ov_hold", 16'(ov_k0), 16'h0001);
        strobe(16'h0000);
        idle(5);

        // back-to-back strobes
        do_reset();
        sample       = 16'h5000;
        sample_valid = 1'b1;
        idle(1);
        chk("b2b_ch1", 16'(ch_k2), 16'h0001);
        sample = 16'h3000;
        idle(1);
        chk("b2b_ch2", 16'(ch_k2), 16'h0002);
        sample = 16'h1000;
        idle(1);
        sample_valid = 1'b0;
        chk("b2b_ch0", 16'(ch_k2), 16'h0000);
        chk("b2b_fv_early", 16'(fv_k2), 16'h0000);
        idle(1);
        chk("b2b_fv", 16'(fv_k2), 16'h0001);
        chk("b2b_vout", vout_k2, 16'h3000);
        chk("b2b_vfc", vfc_k2, 16'h4000);
        idle(1);
        chk("b2b_fv_once", 16'(fv_k2), 16'h0000);
        idle(3);

        // reset in flight after a ch2 strobe
        do_reset();
        strobe(16'h5000);
        idle(5);
        strobe(16'h3000);
        idle(5);
        strobe(16'h1000);
        rst_ni = 1'b0;
        idle(1);
        rst_ni = 1'b1;
        chk("rip_fv", 16'(fv_k2), 16'h0000);
        chk("rip_vout", vout_k2, 16'h0000);
        chk("rip_vfc", vfc_k2, 16'h0000);
        chk("rip_channel", 16'(ch_k2), 16'h0000);
        chk("rip_ov", 16'(ov_k2), 16'h0000);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("rip_no_fv", 16'(fv_k2), 16'h0000);
        end
        run_frame(16'h2000, 16'h1234, 16'h0800);
        chk("rip_new_fv", 16'(fv_k2), 16'h0001);
        chk("rip_new_vout", vout_k2, 16'h1234);
        chk("rip_new_vfc", vfc_k2, 16'h1800);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adc_scan_filter.md
ADC_SCAN_FILTER -- requirements
Module: adc_scan_filter

Interface
REQ-001 SHALL have parameter FILT_SHIFT, default 2, IIR shift K (0 = bypass, legal 0..6).
REQ-002 SHALL have parameter OV_LIMIT, default 16'h7800, Vout over-voltage threshold (code, strict greater-than).
REQ-003 SHALL have parameter OV_COUNT, default 3, consecutive over-limit Vout samples needed to trip (legal 1..15).
REQ-004 SHALL have ports:
- clk_i  in  1  system clock (27 MHz).
- rst_ni  in  1  reset; synchronous, active-low.
- sample_i  in  16  ADC conversion result (ADS1115 two's complement).
- sample_valid_i  in  1  one-cycle strobe; sample_i valid.
- fault_clr_i  in  1  clears sticky fault.
- channel_o  out  2  channel to convert next: 0 = AIN0 Vfc+, 1 = AIN1 Vout, 2 = AIN2 Vfc-.
- v_out_o  out  16  filtered Vout.
- v_fc_o  out  16  filtered Vfc = AIN0 - AIN2, floored at 0.
- frame_valid_o  out  1  one-cycle pulse; v_out_o and v_fc_o updated from a full frame.
- ov_fault_o  out  1  sticky over-voltage fault.

Function
REQ-005 SHALL own the channel sequencer: on each sample_valid_i, the sample belongs to the current channel_o, and channel_o advances 0->1->2->0 in the cycle after the strobe (N+1).
REQ-006 channel_o SHALL never equal 3; if it is ever observed at 3, it SHALL return to 0 on the next cycle.
REQ-007 Input conditioning SHALL clamp any sample with bit15 = 1 (negative code) to 16'h0000 before filtering.
REQ-008 SHALL keep one accumulator per channel, 16+K bits wide, with y = acc >> K and acc_next = acc - y + x; all arithmetic unsigned with no overflow possible.
REQ-009 On the first sample per channel after reset, that channel's accumulator SHALL preload to x << K, so y = x immediately.
REQ-010 With FILT_SHIFT = 0, y SHALL equal the latest conditioned sample.
REQ-011 Stage 1: a strobe at cycle N SHALL update that channel's accumulator at N+1.
REQ-012 Stage 2, at N+2:
- v_out_o SHALL take filtered ch1.
- v_fc_o SHALL take y0 - y2 if y0 >= y2, else 0.
REQ-013 frame_valid_o SHALL pulse high for exactly one cycle at N+2, only when the strobe at N was a ch2 sample and ch0, ch1 and ch2 have each received at least one sample since reset.
REQ-014 Strobes on consecutive cycles SHALL be accepted without loss; each is processed in order through the 2-stage pipeline.
REQ-015 Over-voltage counter:
- On each ch1 accumulator update, if the new y1 > OV_LIMIT, the counter SHALL increment, saturating at OV_COUNT.
- Otherwise the counter SHALL clear to 0.
REQ-016 ov_fault_o SHALL set in the cycle after the counter reaches OV_COUNT, and remain set until fault_clr_i.
REQ-017 fault_clr_i SHALL clear ov_fault_o and the counter on the next edge; if a trip condition occurs in the same cycle, set SHALL win.
REQ-018 Filtered outputs SHALL keep updating while ov_fault_o is set; the block never gates data.

Reset
REQ-019 While rst_ni = 0 at a clk_i edge, the block SHALL set:
- channel_o = 0, v_out_o = 0, v_fc_o = 0, frame_valid_o = 0, ov_fault_o = 0.
- All accumulators = 0, all first-sample flags = 0, OV counter = 0, pipeline valids = 0.
REQ-020 Reset asserted mid-pipeline SHALL discard in-flight samples: no frame_valid_o pulse after reset release until a new full frame completes.
REQ-021 No output SHALL change asynchronously to clk_i.

Verification
REQ-022 Preload/latency, K = 2: after reset, samples ch0 = 0x5000, ch1 = 0x3000, ch2 = 0x1000, one strobe every 10 cycles:
- channel_o sequence 0,1,2,0.
- At the ch2 strobe + 2 cycles: frame_valid_o = 1 for 1 cycle, v_out_o = 0x3000, v_fc_o = 0x4000.
REQ-023 Filter step, K = 2: after preload ch1 = 0x1000, repeated ch1 = 0x2000 samples SHALL give v_out_o 0x1400, 0x1700, 0x1940 on successive frames.
REQ-024 Clamping and floor:
- ch1 = 0x8123 -> v_out_o = 0.
- ch0 = 0x1000 with ch2 = 0x2000 -> v_fc_o = 0.
REQ-025 Over-voltage, OV_COUNT = 3, OV_LIMIT = 0x7800, K = 0:
- ch1 sequence 0x7900, 0x7900, 0x7000, 0x7900 x3 -> ov_fault_o rises only after the 3rd consecutive over-limit sample.
- fault_clr_i pulse with ch1 in range -> ov_fault_o = 0.
- fault_clr_i on the same cycle as a trip -> ov_fault_o stays 1.
REQ-026 Back-to-back and reset:
- Strobes on 3 consecutive cycles are all absorbed; frame_valid_o fires once, at the 3rd strobe + 2.
- rst_ni low one cycle after a ch2 strobe -> no frame_valid_o; all outputs 0; channel_o = 0.
